// File: rtl/sap2_bus_pkg.sv
// sap2_bus_pkg: W-bus sequencer states, agent index constants and default bus sizes
package sap2_bus_pkg;
  localparam int NAGENT_DEF = 8;
  localparam int IDXW_DEF = 3;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;
  localparam int ACC = 0, TMP = 1, B = 2, C = 3, MAR = 4, MDR = 5, OUT = 6, IR = 7;
endpackage

// File: rtl/wbus_onehot_dec.sv
// wbus_onehot_dec: idx -> NAGENT one-hot oh, all zero when en is low or idx >= NAGENT
module wbus_onehot_dec #(
  parameter int NAGENT = 8,
  parameter int IDXW = 3
) (
  input  logic [IDXW-1:0]   idx,
  input  logic              en,
  output logic [NAGENT-1:0] oh
);
  for (genvar i = 0; i < NAGENT; i++) begin : g_bit
    assign oh[i] = en && (idx == IDXW'(i));
  end
endmodule

// File: rtl/wbus_transfer_seq.sv
// wbus_transfer_seq: W-bus move sequencer (IDLE->DRIVE->LOAD->RELEASE) driving E/nL; WBUS_SEQ_BACK2BACK_EN allows accept in RELEASE
module wbus_transfer_seq
  import sap2_bus_pkg::*;
#(
  parameter int NAGENT = NAGENT_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDXW-1:0]   req_src,
  input  logic [NAGENT-1:0] req_dst,
  output logic [NAGENT-1:0] E,
  output logic [NAGENT-1:0] nL,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, state_n;
  logic [IDXW-1:0] src_q, src_n;
  logic [NAGENT-1:0] dst_q, dst_n, src_oh, e_n, nl_n;
  logic accept, bad, legal;
`ifdef WBUS_SEQ_BACK2BACK_EN
  assign req_ready = (state == IDLE) || (state == RELEASE);
`else
  assign req_ready = state == IDLE;
`endif
  wbus_onehot_dec #(.NAGENT(NAGENT), .IDXW(IDXW)) u_chk (
    .idx(req_src),
    .en(1'b1),
    .oh(src_oh)
  );
  wbus_onehot_dec #(.NAGENT(NAGENT), .IDXW(IDXW)) u_e (
    .idx(src_n),
    .en((state_n == DRIVE) || (state_n == LOAD)),
    .oh(e_n)
  );
  always_comb begin
    accept = req_valid && req_ready;
    bad = (32'(req_src) >= NAGENT) || (req_dst == '0) || (|(req_dst & src_oh));
    legal = accept && !bad;
    state_n = legal ? DRIVE : state == DRIVE ? LOAD : state == LOAD ? RELEASE : IDLE;
    src_n = legal ? req_src : src_q;
    dst_n = legal ? req_dst : dst_q;
    nl_n = state_n == LOAD ? ~dst_n : '1;
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      E     <= '0;
      nL    <= '1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      src_q <= src_n;
      dst_q <= dst_n;
      E     <= e_n;
      nL    <= nl_n;
      busy  <= state_n != IDLE;
      done  <= state_n == RELEASE;
      err   <= accept && bad;
    end
  end
endmodule

// File: tb/tb_wbus_transfer_seq.sv
// tb_wbus_transfer_seq: directed checks of the W-bus sequencer with a negedge-capture bus model
module tb_wbus_transfer_seq;
  import sap2_bus_pkg::*;
  localparam int N = 8;
  localparam int W = 4;
`ifdef WBUS_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic CLK = 1'b0, CLR = 1'b0, req_valid = 1'b0, req_ready, busy, done, err;
  logic [W-1:0] req_src = '0;
  logic [N-1:0] req_dst = '0, E, nL;
  logic [7:0] cap [N];
  logic [7:0] wbus;
  logic cap_clr = 1'b0, started = 1'b0;
  int total = 0, bad = 0;
  wbus_transfer_seq #(.NAGENT(N), .IDXW(W)) dut (
    .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .E(E), .nL(nL),
    .busy(busy), .done(done), .err(err)
  );
  always #5 CLK = ~CLK;
  function automatic logic [7:0] src_val(int i);
    return i == ACC ? 8'h0A : i == MDR ? 8'h20 : 8'h10 + 8'(i);
  endfunction
  always_comb begin
    wbus = '0;
    for (int i = 0; i < N; i++) if (E[i]) wbus = wbus | src_val(i);
  end
  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) cap[i] <= cap_clr ? 8'h00 : !nL[i] ? wbus : cap[i];
    if (started) begin
      total++;
      if ($countones(E) > 1 || (nL != '1 && $countones(E) != 1)) begin
        bad++;
        $display("FAIL invariant: E=%b nL=%b (want popcount(E)<=1, nL low only with one-hot E)", E, nL);
      end
    end
  end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic clear_caps();
    cap_clr = 1'b1;
    step();
    cap_clr = 1'b0;
  endtask
  task automatic test_reset();
    CLR = 1'b1;
    step();
    step();
    CLR = 1'b0;
    started = 1'b1;
    total++;
    if ({E, nL, busy, done, err, req_ready} !== {8'h00, 8'hFF, 4'b0001}) begin
      bad++;
      $display("FAIL reset: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", E, nL, busy, done, err, req_ready);
    end
  endtask
  task automatic test_legal();
    clear_caps();
    req_valid = 1'b1; req_src = W'(ACC); req_dst = 8'b0000_0010;
    step();
    req_valid = 1'b0;
    total++;
    if ({E, nL, busy, done, err, req_ready} !== {8'h01, 8'hFF, 4'b1000}) begin
      bad++;
      $display("FAIL legal_drive: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", E, nL, busy, done, err, req_ready);
    end
    step();
    total++;
    if ({E, nL, busy, done, err, req_ready} !== {8'h01, 8'hFD, 4'b1000}) begin
      bad++;
      $display("FAIL legal_load: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", E, nL, busy, done, err, req_ready);
    end
    step();
    total++;
    if ({E, nL, busy, done, err, req_ready} !== {8'h00, 8'hFF, 3'b110, B2B}) begin
      bad++;
      $display("FAIL legal_release: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", E, nL, busy, done, err, req_ready);
    end
    total++;
    if ({cap[TMP], cap[ACC], cap[B]} !== {8'h0A, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL legal_capture: tmp=%h acc=%h b=%h want 0a 00 00", cap[TMP], cap[ACC], cap[B]);
    end
    step();
    total++;
    if ({busy, done, err, req_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL legal_idle: busy=%b done=%b err=%b rdy=%b want 0001", busy, done, err, req_ready);
    end
  endtask
  task automatic test_multicast();
    clear_caps();
    req_valid = 1'b1; req_src = W'(MDR); req_dst = 8'b0000_1101;
    step();
    req_valid = 1'b0;
    total++;
    if ({E, nL} !== {8'b0010_0000, 8'hFF}) begin
      bad++;
      $display("FAIL mcast_drive: E=%b nL=%b", E, nL);
    end
    step();
    total++;
    if ({E, nL} !== {8'b0010_0000, 8'b1111_0010}) begin
      bad++;
      $display("FAIL mcast_load: E=%b nL=%b want 00100000 11110010", E, nL);
    end
    step();
    total++;
    if ({cap[ACC], cap[B], cap[C], cap[TMP], done} !== {8'h20, 8'h20, 8'h20, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL mcast_capture: acc=%h b=%h c=%h tmp=%h done=%b want 20 20 20 00 1", cap[ACC], cap[B], cap[C], cap[TMP], done);
    end
    step();
  endtask
  task automatic test_illegal();
    logic [W-1:0] srcs [3];
    logic [N-1:0] dsts [3];
    srcs = '{W'(ACC), W'(TMP), W'(9)};
    dsts = '{8'h00, 8'b0000_0010, 8'b0000_0001};
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_src = srcs[t]; req_dst = dsts[t];
      step();
      req_valid = 1'b0;
      total++;
      if ({E, nL, busy, done, err, req_ready} !== {8'h00, 8'hFF, 4'b0011}) begin
        bad++;
        $display("FAIL illegal%0d_err: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", t, E, nL, busy, done, err, req_ready);
      end
      step();
      total++;
      if ({E, nL, busy, err} !== {8'h00, 8'hFF, 2'b00}) begin
        bad++;
        $display("FAIL illegal%0d_after: E=%h nL=%h busy=%b err=%b", t, E, nL, busy, err);
      end
    end
  endtask
  task automatic test_reset_mid();
    req_valid = 1'b1; req_src = W'(B); req_dst = 8'b0000_0001;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (nL !== 8'hFE) begin
      bad++;
      $display("FAIL rstmid_load: nL=%h want fe", nL);
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    total++;
    if ({E, nL, busy, done, err, req_ready} !== {8'h00, 8'hFF, 4'b0001}) begin
      bad++;
      $display("FAIL rstmid_abort: E=%h nL=%h busy=%b done=%b err=%b rdy=%b", E, nL, busy, done, err, req_ready);
    end
    step();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_nodone: busy=%b done=%b want 00", busy, done);
    end
  endtask
  task automatic test_back_to_back();
    int d1, d2, drives;
    clear_caps();
    d1 = -1; d2 = -1; drives = 0;
    req_valid = 1'b1; req_src = W'(ACC); req_dst = 8'b0000_0010;
    for (int c = 0; c < 20; c++) begin
      step();
      if (E != '0 && nL == '1) begin
        drives++;
        if (drives == 1) begin
          req_src = W'(C); req_dst = 8'b0001_0000;
        end else req_valid = 1'b0;
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    req_valid = 1'b0;
    total++;
    if (drives !== 2 || d1 < 0 || d2 < 0 || (d2 - d1) !== (B2B ? 3 : 4)) begin
      bad++;
      $display("FAIL b2b_spacing: drives=%0d done_gap=%0d want 2 and %0d", drives, d2 - d1, B2B ? 3 : 4);
    end
    total++;
    if ({cap[TMP], cap[MAR]} !== {8'h0A, 8'h13}) begin
      bad++;
      $display("FAIL b2b_capture: tmp=%h mar=%h want 0a 13", cap[TMP], cap[MAR]);
    end
  endtask
  initial begin
    test_reset();
    test_legal();
    test_multicast();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
